// File: rtl/rs_encoder_serial.sv
// Serial systematic RS(7,5) encoder over GF(8) (x^3+x+1), generator x^2+6x+3, parallel codeword out.
// Latency: codeword valid 1 cycle after the K-th accepted message symbol.
// Backpressure: in_ready drops while a finished codeword waits for cw_ready; no bypass between blocks.
// Optional: define RS_ENC_ERR_INJECT_EN to add err_pos/err_val symbol-error injection at capture.
module rs_encoder_serial #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int K            = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SYMBOL_WIDTH-1:0]     in_symbol,
  output logic                        cw_valid,
  input  logic                        cw_ready,
  output logic [N*SYMBOL_WIDTH-1:0]   codeword,
`ifdef RS_ENC_ERR_INJECT_EN
  input  logic [2:0]                  err_pos,
  input  logic [SYMBOL_WIDTH-1:0]     err_val,
`endif
  output logic [2:0]                  sym_count
);

  localparam int SW = SYMBOL_WIDTH;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  // Multiply by alpha in the polynomial basis: x^3 folds back to x+1.
  function automatic logic [2:0] gf_mul2(input logic [2:0] a);
    return {a[1], a[0] ^ a[2], a[2]};
  endfunction

  // 3 = alpha + 1
  function automatic logic [2:0] gf_mul3(input logic [2:0] a);
    return gf_mul2(a) ^ a;
  endfunction

  // 6 = alpha^2 + alpha
  function automatic logic [2:0] gf_mul6(input logic [2:0] a);
    return gf_mul2(gf_mul2(a)) ^ gf_mul2(a);
  endfunction

  state_t              state_q, state_d;
  logic [SW-1:0]       r1_q, r1_d, r0_q, r0_d;
  logic [K*SW-1:0]     msg_q, msg_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [N*SW-1:0]     cw_q, cw_d;
  logic [N*SW-1:0]     err_mask;

  logic [SW-1:0]       fb, r1_upd, r0_upd;
  logic                accept, last_sym, cw_take;

  // LFSR step for the symbol on the input and the handshake qualifiers.
  always_comb begin
    fb       = in_symbol ^ r1_q;
    r1_upd   = r0_q ^ gf_mul6(fb);
    r0_upd   = gf_mul3(fb);
    accept   = in_valid && in_ready;
    last_sym = accept && (cnt_q == 3'(K - 1));
    cw_take  = cw_valid && cw_ready;
  end

`ifdef RS_ENC_ERR_INJECT_EN
  // Error pattern: err_pos counts symbols from the LSB end starting at 1; 0 or out-of-range injects nothing.
  always_comb begin
    err_mask = '0;
    for (int i = 1; i <= N; i++) begin
      if (err_pos == 3'(i)) err_mask[(i-1)*SW +: SW] = err_val;
    end
  end
`else
  assign err_mask = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // FSM next state: collect K symbols, then hold until the codeword is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (last_sym) state_d = HOLD;
      HOLD:    if (cw_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs: handshakes depend on state only, so no comb path from cw_ready to in_ready.
  always_comb begin
    in_ready = (state_q == COLLECT);
    cw_valid = (state_q == HOLD);
  end

  // Datapath next state: LFSR/shift on accept, capture on the last symbol, clear after the codeword is taken.
  always_comb begin
    r1_d  = r1_q;
    r0_d  = r0_q;
    msg_d = msg_q;
    cnt_d = cnt_q;
    cw_d  = cw_q;
    if (accept) begin
      r1_d  = r1_upd;
      r0_d  = r0_upd;
      msg_d = {msg_q[(K-1)*SW-1:0], in_symbol};
      cnt_d = cnt_q + 3'd1;
    end
    if (last_sym) begin
      // Parity uses the post-update LFSR values so the K-th symbol is included.
      cw_d = {msg_q[(K-1)*SW-1:0], in_symbol, r1_upd, r0_upd} ^ err_mask;
    end
    if (cw_take) begin
      r1_d  = '0;
      r0_d  = '0;
      cnt_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q  <= '0;
      r0_q  <= '0;
      msg_q <= '0;
      cnt_q <= '0;
      cw_q  <= '0;
    end else begin
      r1_q  <= r1_d;
      r0_q  <= r0_d;
      msg_q <= msg_d;
      cnt_q <= cnt_d;
      cw_q  <= cw_d;
    end
  end

  assign codeword  = cw_q;
  assign sym_count = cnt_q;

endmodule

// File: tb/tb_rs_encoder_serial.sv
// Bench for rs_encoder_serial: directed test-plan cases plus random blocks against a syndrome-based model.
// Inputs driven and outputs sampled on the falling edge.
// Expected codewords come from solving c(alpha)=c(alpha^2)=0 with log/antilog GF(8) arithmetic.
module tb_rs_encoder_serial;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_symbol;
  logic        cw_valid;
  logic        cw_ready;
  logic [20:0] codeword;
  logic [2:0]  sym_count;
`ifdef RS_ENC_ERR_INJECT_EN
  logic [2:0]  err_pos;
  logic [2:0]  err_val;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0] msg [5];

  rs_encoder_serial dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_symbol (in_symbol),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .codeword  (codeword),
`ifdef RS_ENC_ERR_INJECT_EN
    .err_pos   (err_pos),
    .err_val   (err_val),
`endif
    .sym_count (sym_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gexp(input int e);
    logic [2:0] tbl [0:6];
    tbl = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
    return tbl[((e % 7) + 7) % 7];
  endfunction

  function automatic int glog(input logic [2:0] v);
    for (int e = 0; e < 7; e++) if (gexp(e) == v) return e;
    return 0;
  endfunction

  function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0 || b == 3'd0) return 3'd0;
    return gexp(glog(a) + glog(b));
  endfunction

  function automatic logic [2:0] gdiv(input logic [2:0] a, input logic [2:0] b);
    if (a == 3'd0) return 3'd0;
    return gexp(glog(a) - glog(b));
  endfunction

  // Codeword c(x) = sum m_i x^(6-i) + p1 x + p0 must vanish at alpha and alpha^2.
  function automatic logic [20:0] model_cw();
    logic [2:0]  s1, s2, p1, p0;
    logic [20:0] cw;
    s1 = 3'd0;
    s2 = 3'd0;
    for (int i = 0; i < 5; i++) begin
      s1 ^= gmul(msg[i], gexp(6 - i));
      s2 ^= gmul(msg[i], gexp(2 * (6 - i)));
    end
    p1 = gdiv(s1 ^ s2, 3'd6);
    p0 = s1 ^ gmul(p1, 3'd2);
    cw = '0;
    for (int i = 0; i < 5; i++) cw = {cw[17:0], msg[i]};
    cw = {cw[14:0], p1, p0};
`ifdef RS_ENC_ERR_INJECT_EN
    if (err_pos >= 3'd1 && err_pos <= 3'd7) cw ^= (21'(err_val) << (3 * (int'(err_pos) - 1)));
`endif
    return cw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send msg[0..4] with random idle gaps; afterwards checks the codeword one cycle after the last accept.
  task automatic send_block(input int max_gap, input bit keep_valid, input logic [2:0] next_sym);
    logic [20:0] exp;
    exp = model_cw();
    for (int i = 0; i < 5; i++) begin
      int gap;
      gap = int'($urandom_range(0, max_gap));
      repeat (gap) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_symbol = 3'($urandom);
        chk("gap_sym_count", 32'(sym_count), 32'(i));
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_symbol = msg[i];
      chk("collect_in_ready", 32'(in_ready), 32'd1);
      chk("collect_cw_valid", 32'(cw_valid), 32'd0);
      chk("collect_sym_count", 32'(sym_count), 32'(i));
    end
    @(negedge clk);
    if (keep_valid) in_symbol = next_sym;
    else            in_valid  = 1'b0;
    chk("latency_cw_valid", 32'(cw_valid), 32'd1);
    chk("hold_in_ready", 32'(in_ready), 32'd0);
    chk("hold_sym_count", 32'(sym_count), 32'd5);
    chk("codeword_model", 32'(codeword), 32'(exp));
  endtask

  // Leave cw_ready low for hold cycles with junk on the input, then take the codeword.
  task automatic consume(input int hold);
    logic [20:0] exp;
    exp = model_cw();
    repeat (hold) begin
      @(negedge clk);
      cw_ready  = 1'b0;
      in_valid  = 1'($urandom);
      in_symbol = 3'($urandom);
      chk("stall_cw_valid", 32'(cw_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_codeword", 32'(codeword), 32'(exp));
      chk("stall_sym_count", 32'(sym_count), 32'd5);
    end
    @(negedge clk);
    cw_ready = 1'b1;
    in_valid = 1'b0;
    chk("take_cw_valid", 32'(cw_valid), 32'd1);
    @(negedge clk);
    cw_ready = 1'b0;
    chk("after_take_cw_valid", 32'(cw_valid), 32'd0);
    chk("after_take_in_ready", 32'(in_ready), 32'd1);
    chk("after_take_sym_count", 32'(sym_count), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_symbol = 3'd0;
    cw_ready  = 1'b0;
`ifdef RS_ENC_ERR_INJECT_EN
    err_pos   = 3'd0;
    err_val   = 3'd0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_cw_valid", 32'(cw_valid), 32'd0);
    chk("reset_codeword", 32'(codeword), 32'd0);
    chk("reset_sym_count", 32'(sym_count), 32'd0);
    reset = 1'b0;

    // Impulse at the highest-degree position, no gaps.
    msg = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    send_block(0, 1'b0, 3'd0);
    chk("const_10000", 32'(codeword), 32'h040032);
    consume(2);

    // Same message with idle gaps, consumer stalls 10 cycles.
    send_block(3, 1'b0, 3'd0);
    chk("const_10000_gaps", 32'(codeword), 32'h040032);
    consume(10);

    // Impulse at the lowest message position, and the all-zero message.
    msg = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    send_block(1, 1'b0, 3'd0);
    chk("const_00001", 32'(codeword), 32'h000073);
    consume(0);
    msg = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    send_block(0, 1'b0, 3'd0);
    chk("const_zero", 32'(codeword), 32'h000000);
    consume(1);

    // Reset after three accepted symbols discards the partial block.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_symbol = 3'($urandom_range(1, 7));
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("partial_sym_count", 32'(sym_count), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_sym_count", 32'(sym_count), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    msg = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    send_block(0, 1'b0, 3'd0);
    chk("const_after_reset", 32'(codeword), 32'h040032);
    consume(0);

    // Back-to-back blocks with cw_ready high: in_ready low for exactly one cycle, held symbol not consumed early.
    cw_ready = 1'b1;
    send_block(0, 1'b1, 3'd0);
    chk("b2b_first", 32'(codeword), 32'h040032);
    msg = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    send_block(0, 1'b0, 3'd0);
    chk("b2b_second", 32'(codeword), 32'h000073);
    @(negedge clk);
    cw_ready = 1'b0;
    chk("b2b_end_cw_valid", 32'(cw_valid), 32'd0);
    chk("b2b_end_in_ready", 32'(in_ready), 32'd1);

    // Reset while a codeword is pending.
    for (int i = 0; i < 5; i++) msg[i] = 3'($urandom);
    send_block(1, 1'b0, 3'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("holdreset_cw_valid", 32'(cw_valid), 32'd0);
    chk("holdreset_codeword", 32'(codeword), 32'd0);
    chk("holdreset_sym_count", 32'(sym_count), 32'd0);

    // Random messages, gaps and consumer stalls.
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 5; i++) msg[i] = 3'($urandom);
      send_block(2, 1'b0, 3'd0);
      consume(int'($urandom_range(0, 3)));
    end

`ifdef RS_ENC_ERR_INJECT_EN
    // Injection: err_pos 3 is the third symbol from the LSB end.
    err_pos = 3'd3;
    err_val = 3'd5;
    msg = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    send_block(0, 1'b0, 3'd0);
    consume(0);
    err_pos = 3'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
